// File: rtl/srl16_bank_ctrl.sv
// srl16_bank_ctrl: shares one serial load/readback path across a bank of SRLC16E cells.
// A write reloads one cell by clocking 16 bits into it MSB first; a read drives the shared
// tap address for one cycle and returns the selected cell's Q as a one-cycle response.
module srl16_bank_ctrl #(
    parameter int unsigned NUM_SRL = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_VALID,
    output logic               WR_READY,
    input  logic [IDX_W-1:0]   WR_IDX,
    input  logic [15:0]        WR_DATA,
    input  logic               RD_VALID,
    output logic               RD_READY,
    input  logic [IDX_W-1:0]   RD_IDX,
    input  logic [3:0]         RD_ADDR,
    output logic               RSP_VALID,
    output logic               RSP_DATA,
    output logic [NUM_SRL-1:0] SRL_CE,
    output logic               SRL_D,
    output logic [3:0]         SRL_A,
    input  logic [NUM_SRL-1:0] SRL_Q,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StRead
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        data_q, data_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [NUM_SRL-1:0] ce_q, ce_d;
    logic               d_q, d_d;
    logic [3:0]         a_q, a_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_data_q, rsp_data_d;
    logic               accept_wr;
    logic               accept_rd;

    // One-hot CE for a cell index; indices past the bank give all-zero so nothing shifts.
    function automatic logic [NUM_SRL-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SRL-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_SRL; i++) begin
            if (idx == i[IDX_W-1:0]) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Q of the indexed cell, or 0 when the index is past the bank.
    function automatic logic tap_select(input logic [IDX_W-1:0] idx,
                                        input logic [NUM_SRL-1:0] q);
        logic bit_v;
        bit_v = 1'b0;
        for (int unsigned i = 0; i < NUM_SRL; i++) begin
            if (idx == i[IDX_W-1:0]) bit_v = q[i];
        end
        return bit_v;
    endfunction

    // Handshake and status; writes take priority over a simultaneous read.
    always_comb begin
        WR_READY  = (state_q == StIdle) & ~RST;
        RD_READY  = (state_q == StIdle) & ~RST & ~WR_VALID;
        BUSY      = (state_q != StIdle) & ~RST;
        accept_wr = WR_VALID & WR_READY;
        accept_rd = RD_VALID & RD_READY;
        SRL_CE    = ce_q;
        SRL_D     = d_q;
        SRL_A     = a_q;
        RSP_VALID = rsp_valid_q;
        RSP_DATA  = rsp_data_q;
    end

    // Next-state: sequence the 16 shifts of a write, or the single sample cycle of a read.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        ce_d        = '0;
        d_d         = 1'b0;
        a_d         = a_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept_wr) begin
                    state_d = StShift;
                    idx_d   = WR_IDX;
                    ce_d    = idx_onehot(WR_IDX);
                    d_d     = WR_DATA[15];
                    // data_q keeps the bits still to be sent, next one at the top.
                    data_d  = {WR_DATA[14:0], 1'b0};
                    cnt_d   = 4'd0;
                end else if (accept_rd) begin
                    state_d = StRead;
                    idx_d   = RD_IDX;
                    a_d     = RD_ADDR;
                end
            end
            StShift: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StIdle;
                end else begin
                    ce_d   = idx_onehot(idx_q);
                    d_d    = data_q[15];
                    data_d = {data_q[14:0], 1'b0};
                end
            end
            StRead: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_data_d  = tap_select(idx_q, SRL_Q);
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered bank-side outputs, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            ce_q        <= '0;
            d_q         <= 1'b0;
            a_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            d_q         <= d_d;
            a_q         <= a_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_srl16_bank_ctrl.sv
// Bench for srl16_bank_ctrl: a bank of SRLC16E cells driven by the DUT, a transaction-timeline
// reference model checked every cycle, directed scenarios with literal expectations, then
// randomized traffic.
module tb_srl16_bank_ctrl;

    localparam int unsigned NUM_SRL = 3;
    localparam int unsigned IDX_W   = 2;

    logic               CLK = 1'b0;
    logic               RST;
    logic               WR_VALID;
    logic               WR_READY;
    logic [IDX_W-1:0]   WR_IDX;
    logic [15:0]        WR_DATA;
    logic               RD_VALID;
    logic               RD_READY;
    logic [IDX_W-1:0]   RD_IDX;
    logic [3:0]         RD_ADDR;
    logic               RSP_VALID;
    logic               RSP_DATA;
    logic [NUM_SRL-1:0] SRL_CE;
    logic               SRL_D;
    logic [3:0]         SRL_A;
    logic [NUM_SRL-1:0] SRL_Q;
    logic               BUSY;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int rsp_count = 0;

    always #5 CLK = ~CLK;

    srl16_bank_ctrl #(
        .NUM_SRL (NUM_SRL),
        .IDX_W   (IDX_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_VALID  (WR_VALID),
        .WR_READY  (WR_READY),
        .WR_IDX    (WR_IDX),
        .WR_DATA   (WR_DATA),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .RD_IDX    (RD_IDX),
        .RD_ADDR   (RD_ADDR),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .SRL_CE    (SRL_CE),
        .SRL_D     (SRL_D),
        .SRL_A     (SRL_A),
        .SRL_Q     (SRL_Q),
        .BUSY      (BUSY)
    );

    // SRLC16E bank: shift in at tap 0 when CE is high; Q is the addressed tap.
    logic [15:0] bank [NUM_SRL] = '{16'h0000, 16'h1234, 16'hBEEF};

    always @(posedge CLK) begin
        for (int i = 0; i < NUM_SRL; i++) begin
            if (SRL_CE[i]) bank[i] <= {bank[i][14:0], SRL_D};
        end
    end

    always_comb begin
        SRL_Q = '0;
        for (int i = 0; i < NUM_SRL; i++) SRL_Q[i] = bank[i][SRL_A];
    end

    always @(negedge CLK) begin
        if (RSP_VALID === 1'b1) rsp_count <= rsp_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: timeline of accepted transactions ----------------
    // cyc numbers clock cycles; a write accepted in cycle t shifts in cycles t+1..t+16,
    // a read accepted in t occupies t+1 and responds in t+2.
    logic [15:0] ref_cell [NUM_SRL] = '{16'h0000, 16'h1234, 16'hBEEF};
    int              cyc      = 0;
    bit              w_active = 1'b0;
    int              sh_first = 0;
    logic [IDX_W-1:0] w_idx   = '0;
    logic [15:0]     w_data   = '0;
    bit              r_active = 1'b0;
    int              rd_cycle = 0;
    logic            r_val    = 1'b0;
    logic [3:0]      m_a      = '0;
    logic            m_rsp_v  = 1'b0;
    logic            m_rsp_d  = 1'b0;

    function automatic bit in_shift_now();
        return w_active && (cyc >= sh_first) && (cyc <= sh_first + 15);
    endfunction

    function automatic bit in_read_now();
        return r_active && (cyc == rd_cycle);
    endfunction

    // Cell contents after n MSB-first shifts of data into old.
    function automatic logic [15:0] after_shifts(input logic [15:0] old, input logic [15:0] data,
                                                 input int n);
        logic [31:0] t;
        t = ({16'b0, old} << n) | ({16'b0, data} >> (16 - n));
        return t[15:0];
    endfunction

    function automatic logic [NUM_SRL-1:0] exp_ce_now();
        logic [NUM_SRL-1:0] v;
        v = '0;
        if (in_shift_now() && int'(w_idx) < NUM_SRL) v[w_idx] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_d_now();
        if (in_shift_now()) return w_data[15 - (cyc - sh_first)];
        return 1'b0;
    endfunction

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        m_rsp_v <= 1'b0;
        if (in_shift_now() && (RST || cyc == sh_first + 15)) begin
            if (int'(w_idx) < NUM_SRL)
                ref_cell[w_idx] <= after_shifts(ref_cell[w_idx], w_data, cyc - sh_first + 1);
            w_active <= 1'b0;
        end
        if (RST) begin
            w_active <= 1'b0;
            r_active <= 1'b0;
            m_a      <= '0;
            m_rsp_d  <= 1'b0;
        end else begin
            if (in_read_now()) begin
                m_rsp_v  <= 1'b1;
                m_rsp_d  <= r_val;
                r_active <= 1'b0;
            end
            if (!in_shift_now() && !in_read_now()) begin
                if (WR_VALID) begin
                    w_active <= 1'b1;
                    sh_first <= cyc + 1;
                    w_idx    <= WR_IDX;
                    w_data   <= WR_DATA;
                end else if (RD_VALID) begin
                    r_active <= 1'b1;
                    rd_cycle <= cyc + 1;
                    r_val    <= (int'(RD_IDX) < NUM_SRL) ? ref_cell[RD_IDX][RD_ADDR] : 1'b0;
                    m_a      <= RD_ADDR;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("WR_READY", WR_READY, !(in_shift_now() || in_read_now()) && !RST);
            chk("RD_READY", RD_READY,
                !(in_shift_now() || in_read_now()) && !RST && !WR_VALID);
            chk("BUSY", BUSY, (in_shift_now() || in_read_now()) && !RST);
            chk("SRL_CE", SRL_CE, exp_ce_now());
            chk("SRL_D", SRL_D, exp_d_now());
            chk("SRL_A", SRL_A, m_a);
            chk("RSP_VALID", RSP_VALID, m_rsp_v);
            chk("RSP_DATA", RSP_DATA, m_rsp_d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_read(input logic [IDX_W-1:0] idx, input logic [3:0] addr,
                           output logic r);
        RD_VALID = 1'b1;
        RD_IDX   = idx;
        RD_ADDR  = addr;
        step();
        RD_VALID = 1'b0;
        step();
        @(negedge CLK);
        chk("rsp_pulse", RSP_VALID, 1'b1);
        r = RSP_DATA;
        step();
    endtask

    logic [15:0] dseq;
    logic [15:0] rbits;
    logic [15:0] b0;
    logic        r;
    int          hits;
    int          k;
    int          cnt0;

    initial begin
        RST = 1'b1; WR_VALID = 1'b0; WR_IDX = '0; WR_DATA = '0;
        RD_VALID = 1'b0; RD_IDX = '0; RD_ADDR = '0;
        step();
        chk_en = 1'b1;
        step();
        step();
        RST = 1'b0;

        // Reset in the 8th shift cycle of an all-ones write into cell 0.
        WR_VALID = 1'b1; WR_IDX = 2'd0; WR_DATA = 16'hFFFF;
        step();
        WR_VALID = 1'b0;
        repeat (7) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ce_drop", SRL_CE, 3'b000);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_a", SRL_A, 4'h0);
        chk("rst_rsp_v", RSP_VALID, 1'b0);
        chk("partial_bank", bank[0], 16'h00FF);
        chk("partial_model", ref_cell[0], 16'h00FF);
        step();

        // Full write of 16'hA5C3 into cell 1, then read back every tap.
        WR_VALID = 1'b1; WR_IDX = 2'd1; WR_DATA = 16'hA5C3;
        step();
        WR_VALID = 1'b0;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            dseq[15 - i] = SRL_D;
            if (SRL_CE == 3'b010 && WR_READY == 1'b0) hits++;
        end
        chk("ce_window", hits, 16);
        chk("d_sequence", dseq, 16'hA5C3);
        @(negedge CLK);
        chk("wr_ready_back", WR_READY, 1'b1);
        chk("ce_after", SRL_CE, 3'b000);
        step();
        for (int a = 0; a < 16; a++) begin
            do_read(2'd1, 4'(a), r);
            rbits[a] = r;
        end
        chk("readback_a5c3", rbits, 16'hA5C3);

        // Write and read together: write first, read waits until the write finishes.
        b0 = bank[0];
        WR_VALID = 1'b1; WR_IDX = 2'd2; WR_DATA = 16'hDA0F;
        RD_VALID = 1'b1; RD_IDX = 2'd0; RD_ADDR = 4'd5;
        @(negedge CLK);
        chk("prio_rd_ready", RD_READY, 1'b0);
        chk("prio_wr_ready", WR_READY, 1'b1);
        step();
        WR_VALID = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge CLK);
            if (RD_READY === 1'b1) break;
            step();
            k++;
        end
        chk("rd_wait", k, 16);
        step();
        RD_VALID = 1'b0;
        step();
        @(negedge CLK);
        chk("prio_rsp_v", RSP_VALID, 1'b1);
        chk("prio_rsp_d", RSP_DATA, 1'b1);
        chk("cell0_untouched", bank[0], b0);
        chk("cell2_loaded", bank[2], 16'hDA0F);
        step();

        // Back-to-back reads of cells 0, 2, 3 at tap 15.
        cnt0 = rsp_count;
        RD_VALID = 1'b1; RD_ADDR = 4'hF; RD_IDX = 2'd0;
        step();
        RD_IDX = 2'd2;
        step();
        step();
        RD_IDX = 2'd3;
        step();
        step();
        RD_VALID = 1'b0;
        step();
        step();
        chk("b2b_pulses", rsp_count - cnt0, 3);

        // Write to an index past the bank: busy, no CE, nothing changes.
        WR_VALID = 1'b1; WR_IDX = 2'd3; WR_DATA = 16'hFFFF;
        step();
        WR_VALID = 1'b0;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (BUSY == 1'b1 && SRL_CE == 3'b000) hits++;
        end
        chk("oob_busy_no_ce", hits, 16);
        step();
        do_read(2'd3, 4'd7, r);
        chk("oob_read", r, 1'b0);

        // Read then reset during the sample cycle: no response, data cleared.
        do_read(2'd1, 4'd0, r);
        chk("pre_rst_read", r, 1'b1);
        RD_VALID = 1'b1; RD_IDX = 2'd1; RD_ADDR = 4'd0;
        step();
        RD_VALID = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rd_rst_rsp_v", RSP_VALID, 1'b0);
        chk("rd_rst_rsp_d", RSP_DATA, 1'b0);
        step();

        // Randomized traffic, occasional resets.
        for (int i = 0; i < 1500; i++) begin
            RST      = ($urandom_range(0, 199) == 0);
            WR_VALID = ($urandom_range(0, 9) == 0);
            WR_IDX   = IDX_W'($urandom);
            WR_DATA  = 16'($urandom);
            RD_VALID = ($urandom_range(0, 2) == 0);
            RD_IDX   = IDX_W'($urandom);
            RD_ADDR  = 4'($urandom);
            step();
        end
        RST = 1'b0; WR_VALID = 1'b0; RD_VALID = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
